block_assembler: RTL and testbench

BLOCK_ASSEMBLER -- requirements
Module: block_assembler

---
 rtl/block_assembler.sv | 141 ++++++++++++++
 tb/tb_block_assembler.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_assembler.sv
// Packs LANE_BYTES-wide beats into BYTES_PER_BLOCK-byte blocks behind a two-stage
// (assembly + output) buffer. Define BLOCK_ASSEMBLER_PKCS7_EN for PKCS#7 padding.
module block_assembler #(
    parameter int unsigned BYTES_PER_BLOCK = 16,
    parameter int unsigned LANE_BYTES      = 1
) (
    input  logic                                   clk_in,
    input  logic                                   rst_n_in,
    input  logic [LANE_BYTES*8-1:0]                data_in,
    input  logic                                   valid_in,
    input  logic                                   last_in,
    output logic                                   ready_out,
    output logic [BYTES_PER_BLOCK*8-1:0]           block_out,
    output logic                                   valid_out,
    input  logic                                   ready_in,
    output logic [$clog2(BYTES_PER_BLOCK+1)-1:0]   count_out,
    output logic                                   last_out
);
    localparam int unsigned CW = $clog2(BYTES_PER_BLOCK + 1);
    localparam int unsigned BW = BYTES_PER_BLOCK * 8;
    localparam logic [7:0]  PAD_FULL = 8'(BYTES_PER_BLOCK);
`ifdef BLOCK_ASSEMBLER_PKCS7_EN
    localparam bit PKCS7_EN = 1'b1;
`else
    localparam bit PKCS7_EN = 1'b0;
`endif

    typedef enum logic [1:0] {StFill, StStall, StPad} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_fill;
    logic [BW-1:0]   r_asm;
    logic [CW-1:0]   r_held_count;
    logic            r_held_last;
    logic [BW-1:0]   r_out_block;
    logic            r_out_valid;
    logic [CW-1:0]   r_out_count;
    logic            r_out_last;

    logic [CW-1:0]   w_new_fill;
    logic            w_full;
    logic            w_complete;
    logic            w_accept;
    logic            w_out_free;
    logic            w_to_pad;
    logic            w_held_to_pad;
    logic [7:0]      w_pad_byte;
    logic [BW-1:0]   w_blk;

    assign ready_out  = rst_n_in && (r_state == StFill);
    assign w_accept   = valid_in && ready_out;
    assign w_out_free = !r_out_valid || ready_in;

    always_comb begin
        w_new_fill    = r_fill + CW'(LANE_BYTES);
        w_full        = (w_new_fill == CW'(BYTES_PER_BLOCK));
        w_complete    = w_full || last_in;
        w_to_pad      = PKCS7_EN && last_in && w_full;
        w_held_to_pad = PKCS7_EN && r_held_last && (r_held_count == CW'(BYTES_PER_BLOCK));
        w_pad_byte    = PKCS7_EN ? 8'(int'(BYTES_PER_BLOCK) - int'(w_new_fill)) : 8'h00;
        w_blk         = '0;
        // Bytes past the new fill level are always rebuilt as padding, so stale
        // assembly contents can never leak into a later block.
        for (int i = 0; i < int'(BYTES_PER_BLOCK); i++) begin
            if (i < int'(r_fill)) begin
                w_blk[i*8 +: 8] = r_asm[i*8 +: 8];
            end else if (i < int'(w_new_fill)) begin
                w_blk[i*8 +: 8] = data_in[(i - int'(r_fill))*8 +: 8];
            end else begin
                w_blk[i*8 +: 8] = w_pad_byte;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state      <= StFill;
            r_fill       <= '0;
            r_asm        <= '0;
            r_held_count <= '0;
            r_held_last  <= 1'b0;
            r_out_block  <= '0;
            r_out_valid  <= 1'b0;
            r_out_count  <= '0;
            r_out_last   <= 1'b0;
        end else begin
            if (r_out_valid && ready_in) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                StFill: begin
                    if (w_accept) begin
                        if (w_complete) begin
                            r_fill <= '0;
                            if (w_out_free) begin
                                r_out_block <= w_blk;
                                r_out_count <= w_new_fill;
                                r_out_last  <= last_in && !w_to_pad;
                                r_out_valid <= 1'b1;
                                r_state     <= w_to_pad ? StPad : StFill;
                            end else begin
                                r_asm        <= w_blk;
                                r_held_count <= w_new_fill;
                                r_held_last  <= last_in;
                                r_state      <= StStall;
                            end
                        end else begin
                            r_asm  <= w_blk;
                            r_fill <= w_new_fill;
                        end
                    end
                end
                StStall: begin
                    if (w_out_free) begin
                        r_out_block <= r_asm;
                        r_out_count <= r_held_count;
                        r_out_last  <= r_held_last && !w_held_to_pad;
                        r_out_valid <= 1'b1;
                        r_state     <= w_held_to_pad ? StPad : StFill;
                    end
                end
                StPad: begin
                    if (w_out_free) begin
                        r_out_block <= {BYTES_PER_BLOCK{PAD_FULL}};
                        r_out_count <= '0;
                        r_out_last  <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= StFill;
                    end
                end
                default: r_state <= StFill;
            endcase
        end
    end

    assign block_out = r_out_block;
    assign valid_out = r_out_valid;
    assign count_out = r_out_count;
    assign last_out  = r_out_last;

endmodule

// File: tb/tb_block_assembler.sv
// Scoreboard bench for block_assembler: one instance with 1-byte lanes, one with 4-byte lanes.
module tb_block_assembler;
    localparam int BPB = 16;
`ifdef BLOCK_ASSEMBLER_PKCS7_EN
    localparam bit PKCS = 1'b1;
`else
    localparam bit PKCS = 1'b0;
`endif

    typedef logic [7:0] u8_t;
    typedef u8_t seq_t[$];
    typedef struct {
        logic [127:0] blk;
        logic [4:0]   cnt;
        logic         lst;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [7:0]   d0_data;
    logic         d0_valid, d0_last, d0_ready, d0_vout, d0_rin, d0_lout;
    logic [127:0] d0_block;
    logic [4:0]   d0_count;

    logic [31:0]  d1_data;
    logic         d1_valid, d1_last, d1_ready, d1_vout, d1_rin, d1_lout;
    logic [127:0] d1_block;
    logic [4:0]   d1_count;

    exp_t q0[$];
    exp_t q1[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cycle = 0;

    block_assembler #(.BYTES_PER_BLOCK(16), .LANE_BYTES(1)) u_dut0 (
        .clk_in(clk), .rst_n_in(rst_n), .data_in(d0_data), .valid_in(d0_valid),
        .last_in(d0_last), .ready_out(d0_ready), .block_out(d0_block), .valid_out(d0_vout),
        .ready_in(d0_rin), .count_out(d0_count), .last_out(d0_lout)
    );

    block_assembler #(.BYTES_PER_BLOCK(16), .LANE_BYTES(4)) u_dut1 (
        .clk_in(clk), .rst_n_in(rst_n), .data_in(d1_data), .valid_in(d1_valid),
        .last_in(d1_last), .ready_out(d1_ready), .block_out(d1_block), .valid_out(d1_vout),
        .ready_in(d1_rin), .count_out(d1_count), .last_out(d1_lout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic seq_t make_seq(int base, int n);
        seq_t s;
        for (int i = 0; i < n; i++) s.push_back(8'(base + i));
        return s;
    endfunction

    // Reference blocking of a message; unterminated messages yield only full blocks.
    function automatic void push_exp(int which, seq_t msg, bit has_last);
        int   n;
        int   idx;
        exp_t e;
        n   = msg.size();
        idx = 0;
        while ((n - idx >= BPB) || (has_last && idx < n)) begin
            int chunk;
            chunk = (n - idx >= BPB) ? BPB : n - idx;
            e.blk = '0;
            for (int j = 0; j < BPB; j++) begin
                if (j < chunk) e.blk[j*8 +: 8] = msg[idx + j];
                else           e.blk[j*8 +: 8] = PKCS ? 8'(BPB - chunk) : 8'h00;
            end
            e.cnt = 5'(chunk);
            e.lst = has_last && (idx + chunk == n) && !(PKCS && chunk == BPB);
            if (which == 0) q0.push_back(e); else q1.push_back(e);
            idx += chunk;
        end
        if (has_last && PKCS && (n % BPB == 0)) begin
            e.blk = {16{8'h10}};
            e.cnt = 5'd0;
            e.lst = 1'b1;
            if (which == 0) q0.push_back(e); else q1.push_back(e);
        end
    endfunction

    task automatic send0(seq_t msg, bit has_last);
        for (int i = 0; i < msg.size(); i++) begin
            int t;
            t = 0;
            d0_data  = msg[i];
            d0_last  = has_last && (i == msg.size() - 1);
            d0_valid = 1'b1;
            while (!d0_ready) begin
                @(posedge clk); #1;
                t++;
                if (t > 200) begin
                    $display("FAIL dut0_send_timeout: ready_out stuck at 0, expected 1");
                    $fatal(1, "dut0 send timeout");
                end
            end
            @(posedge clk); #1;
        end
        d0_valid = 1'b0;
        d0_last  = 1'b0;
    endtask

    task automatic send1(seq_t msg, bit has_last);
        for (int b = 0; b < msg.size() / 4; b++) begin
            int t;
            t = 0;
            d1_data  = {msg[4*b+3], msg[4*b+2], msg[4*b+1], msg[4*b]};
            d1_last  = has_last && (b == msg.size() / 4 - 1);
            d1_valid = 1'b1;
            while (!d1_ready) begin
                @(posedge clk); #1;
                t++;
                if (t > 200) begin
                    $display("FAIL dut1_send_timeout: ready_out stuck at 0, expected 1");
                    $fatal(1, "dut1 send timeout");
                end
            end
            @(posedge clk); #1;
        end
        d1_valid = 1'b0;
        d1_last  = 1'b0;
    endtask

    always @(negedge clk) begin : mon0
        exp_t e;
        if (rst_n && d0_vout && d0_rin) begin
            if (q0.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dut0_unexpected_block: got %0h, no block expected", d0_block);
            end else begin
                e = q0.pop_front();
                check("dut0_block", d0_block, e.blk);
                check("dut0_count", 128'(d0_count), 128'(e.cnt));
                check("dut0_last", 128'(d0_lout), 128'(e.lst));
            end
        end
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (rst_n && d1_vout && d1_rin) begin
            if (q1.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dut1_unexpected_block: got %0h, no block expected", d1_block);
            end else begin
                e = q1.pop_front();
                check("dut1_block", d1_block, e.blk);
                check("dut1_count", 128'(d1_count), 128'(e.cnt));
                check("dut1_last", 128'(d1_lout), 128'(e.lst));
            end
        end
    end

    initial begin
        seq_t msg;
        exp_t e;
        int   t0;
        int   t;
        d0_data = '0; d0_valid = 1'b0; d0_last = 1'b0; d0_rin = 1'b1;
        d1_data = '0; d1_valid = 1'b0; d1_last = 1'b0; d1_rin = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("reset_ready0", 128'(d0_ready), 128'(0));
        check("reset_ready1", 128'(d1_ready), 128'(0));
        check("reset_valid", 128'(d0_vout), 128'(0));
        check("reset_count", 128'(d0_count), 128'(0));
        check("reset_last", 128'(d0_lout), 128'(0));
        check("reset_block", d0_block, 128'(0));
        rst_n = 1'b1;
        #1;
        check("release_ready0", 128'(d0_ready), 128'(1));
        check("release_ready1", 128'(d1_ready), 128'(1));
        @(posedge clk); #1;

        // Full 16-byte message, one byte per beat
        msg = make_seq(8'h00, 16);
        push_exp(0, msg, 1'b1);
        send0(msg, 1'b1);
        check("latency_valid", 128'(d0_vout), 128'(1));
        repeat (3) @(posedge clk);
        #1;

        // Short message: hand-computed padded block
        e.blk = PKCS ? 128'h0B0B0B0B0B0B0B0B0B0B0BA4A3A2A1A0
                     : 128'h0000000000000000000000A4A3A2A1A0;
        e.cnt = 5'd5;
        e.lst = 1'b1;
        q0.push_back(e);
        send0(make_seq(8'hA0, 5), 1'b1);
        repeat (3) @(posedge clk);
        #1;

        // 20-byte message spans a full and a partial block
        msg = make_seq(8'h80, 20);
        push_exp(0, msg, 1'b1);
        send0(msg, 1'b1);
        repeat (3) @(posedge clk);
        #1;

        // Sustained throughput: 32 beats in 32 cycles
        msg = make_seq(8'hC0, 32);
        push_exp(0, msg, 1'b1);
        t0 = cycle;
        send0(msg, 1'b1);
        check("no_bubbles", 128'(cycle - t0), 128'(32));
        repeat (3) @(posedge clk);
        #1;

        // Downstream backpressure on the 1-byte lane
        d0_rin = 1'b0;
        msg = make_seq(8'h10, 16);
        push_exp(0, msg, 1'b0);
        send0(msg, 1'b0);
        msg = make_seq(8'h20, 16);
        push_exp(0, msg, 1'b1);
        send0(msg, 1'b1);
        check("stall_ready0", 128'(d0_ready), 128'(0));
        check("stall_valid0", 128'(d0_vout), 128'(1));
        d0_rin = 1'b1;
        repeat (6) @(posedge clk);
        #1;

        // 4-byte lane: second block stalls behind a held first block for 10 cycles
        d1_rin = 1'b0;
        msg = make_seq(8'h60, 32);
        push_exp(1, msg, 1'b1);
        send1(msg, 1'b1);
        check("stall_ready1", 128'(d1_ready), 128'(0));
        check("stall_valid1", 128'(d1_vout), 128'(1));
        repeat (10) @(posedge clk);
        #1;
        check("stall_hold_ready1", 128'(d1_ready), 128'(0));
        check("stall_hold_valid1", 128'(d1_vout), 128'(1));
        check("stall_hold_block1", d1_block, 128'h6F6E6D6C6B6A69686766656463626160);
        d1_rin = 1'b1;
        repeat (6) @(posedge clk);
        #1;

        // Asynchronous reset with a held block and a 7-byte partial assembly
        d0_rin = 1'b0;
        send0(make_seq(8'h30, 16), 1'b0);
        send0(make_seq(8'h40, 7), 1'b0);
        check("pre_reset_valid", 128'(d0_vout), 128'(1));
        #2;
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        #1;
        check("async_reset_valid", 128'(d0_vout), 128'(0));
        check("async_reset_ready", 128'(d0_ready), 128'(0));
        check("async_reset_count", 128'(d0_count), 128'(0));
        @(posedge clk); #1;
        rst_n  = 1'b1;
        d0_rin = 1'b1;
        @(posedge clk); #1;
        msg = make_seq(8'h50, 16);
        push_exp(0, msg, 1'b1);
        send0(msg, 1'b1);

        t = 0;
        while ((q0.size() != 0 || q1.size() != 0) && t < 100) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("scoreboard_drained", 128'(q0.size() + q1.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
